msrv32_dmem_responder: RTL and testbench
========================================

MSRV32_DMEM_RESPONDER -- requirements
Module: msrv32_dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, giving the number of 32-bit memory words (power of two, at least 4).
REQ-002 SHALL have parameter WAIT_STATES, default 1, giving the ready-low cycles per transfer (0..15).
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 ms_riscv32_mp_clk_in  input  1  clock; all state updates on the rising edge.
REQ-005 ms_riscv32_mp_rst_in  input  1  synchronous active-high reset.
REQ-006 ms_riscv32_mp_dmaddr_in  input  32  byte address from the store/load path.
REQ-007 ms_riscv32_mp_dmdata_in  input  32  write data, already lane-aligned.
REQ-008 ms_riscv32_mp_dmwr_mask_in  input  4  byte-lane write enables; bit i selects byte [8i+7:8i].
REQ-009 ms_riscv32_mp_dmwr_req_in  input  1  1 = write, 0 = read.
REQ-010 ahb_htrans_in  input  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
REQ-011 ms_riscv32_mp_dmdata_rd_out  output  32  read data.
REQ-012 ahb_ready_out  output  1  transfer-complete / ready-to-accept.
REQ-013 ahb_resp_out  output  1  0 = OKAY, 1 = ERROR.

Function
REQ-014 A transfer SHALL be accepted on a rising edge where ahb_ready_out=1 and ahb_htrans_in is 10 or 11; codes 00 and 01 SHALL be ignored.
REQ-015 On acceptance, address, data, mask and wr_req SHALL be captured in internal registers; inputs SHALL be ignored while ahb_ready_out=0.
REQ-016 The word index SHALL be dmaddr_in[log2(DEPTH_WORDS)+1:2]; addr[1:0] SHALL be ignored (the mask carries lane information).
REQ-017 The FSM states SHALL be IDLE, WAIT, ERR1 and ERR2.
REQ-018 With WAIT_STATES=0, the access SHALL occur at the accept edge; ahb_ready_out stays 1, read data is valid the following cycle, and back-to-back transfers run every cycle.
REQ-019 With WAIT_STATES=N>0, the accept edge SHALL move IDLE to WAIT and load the counter with N; ahb_ready_out SHALL be 0 for exactly N cycles.
REQ-020 In WAIT, the counter SHALL decrement each cycle; at the edge where the counter reaches 1, the access SHALL be performed and the FSM SHALL return to IDLE with ahb_ready_out=1 and read data valid.
REQ-021 A write SHALL update only the lanes whose mask bit is 1; mask 0000 SHALL leave memory unchanged and still give an OKAY response.
REQ-022 A read SHALL return the full addressed word on ms_riscv32_mp_dmdata_rd_out, held until the next completed read.
REQ-023 A write SHALL NOT change ms_riscv32_mp_dmdata_rd_out.
REQ-024 A read immediately following a write to the same word SHALL return the newly written data.
REQ-025 In IDLE with no transfer, ahb_ready_out SHALL be 1 and ahb_resp_out SHALL be 0.

Reset
REQ-026 Reset SHALL force: state IDLE, counter 0, ahb_ready_out=1, ahb_resp_out=0, ms_riscv32_mp_dmdata_rd_out=0.
REQ-027 Memory contents SHALL NOT be cleared by reset.
REQ-028 Reset asserted during WAIT or ERR1/ERR2 SHALL abandon the pending transfer; a pending write SHALL NOT be committed.
REQ-029 Reset SHALL take priority over a simultaneous transfer acceptance.

Configuration
REQ-030 Macro MSRV32_DMEM_RANGE_CHECK_EN defined: an accepted transfer with dmaddr_in >= 4*DEPTH_WORDS SHALL take no memory action.
REQ-031 For such an out-of-range transfer, the FSM SHALL go IDLE->ERR1 (ready=0, resp=1) -> ERR2 (ready=1, resp=1) -> IDLE, ignoring WAIT_STATES.
REQ-032 Macro MSRV32_DMEM_RANGE_CHECK_EN undefined: the address SHALL wrap modulo 4*DEPTH_WORDS, ahb_resp_out SHALL be tied to 0, and the ERR1/ERR2 states SHALL NOT exist.

Verification
REQ-033 Byte write: WAIT_STATES=1, NONSEQ, addr 0x1, data 0x0000FF00, mask 0010, wr=1 -> ready 0 for 1 cycle, then 1; reading addr 0x0 returns 0x0000FF00 in byte 1 with all other bytes unchanged.
REQ-034 Halfword then full word: write 0xFFFF0000 mask 1100 to addr 0x2, then 0xAAAAAAAA mask 1111 to addr 0x8 -> reads return 0xFFFFxxxx (low half unchanged) and 0xAAAAAAAA.
REQ-035 Back-to-back: WAIT_STATES=0, write 0x12345678 to addr 0x4, then read addr 0x4 on the next cycle -> read data 0x12345678 one cycle after the read is accepted, ready never low.
REQ-036 Hold during wait: WAIT_STATES=3 -> ready low for exactly 3 cycles; a changed address and NONSEQ offered during the wait is ignored.
REQ-037 Range check: with the macro defined, DEPTH_WORDS=1024, write to addr 0x1000 -> resp 1 with ready 0, then resp 1 with ready 1, and memory is unchanged; with the macro undefined, the same write lands at word 0.
REQ-038 Reset in WAIT: assert reset during WAIT of a write -> ready=1, rd_out=0 next cycle, and the target word is unchanged.

Source files
------------

// File: rtl/msrv32_dmem_responder.sv
// rtl/msrv32_dmem_responder.sv - wait-state data memory responder for the msrv32 load/store path
// Define MSRV32_DMEM_RANGE_CHECK_EN to answer out-of-range addresses with a two-cycle ERROR instead of wrapping.
module msrv32_dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_in,
  input  logic [31:0] ms_riscv32_mp_dmaddr_in,
  input  logic [31:0] ms_riscv32_mp_dmdata_in,
  input  logic [3:0]  ms_riscv32_mp_dmwr_mask_in,
  input  logic        ms_riscv32_mp_dmwr_req_in,
  input  logic [1:0]  ahb_htrans_in,
  output logic [31:0] ms_riscv32_mp_dmdata_rd_out,
  output logic        ahb_ready_out,
  output logic        ahb_resp_out
);
  localparam int AW = $clog2(DEPTH_WORDS);

`ifdef MSRV32_DMEM_RANGE_CHECK_EN
  typedef enum logic [1:0] {IDLE, WAIT, ERR1, ERR2} state_t;
`else
  typedef enum logic [0:0] {IDLE, WAIT} state_t;
`endif

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] widx_q, widx_d;
  logic [31:0]   data_q, data_d;
  logic [3:0]    mask_q, mask_d;
  logic          wr_q, wr_d;
  logic [31:0]   rd_q, rd_d;

  logic [31:0]   mem [DEPTH_WORDS];

  logic          accept;
  logic          acc_en;
  logic          acc_wr;
  logic [AW-1:0] acc_idx;
  logic [31:0]   acc_data;
  logic [3:0]    acc_mask;
  logic [AW-1:0] in_idx;
  logic          unused_addr;

  assign in_idx = ms_riscv32_mp_dmaddr_in[AW+1:2];

`ifdef MSRV32_DMEM_RANGE_CHECK_EN
  logic oor;
  assign oor           = (ms_riscv32_mp_dmaddr_in >= 32'(4 * DEPTH_WORDS));
  assign ahb_ready_out = (state_q != WAIT) && (state_q != ERR1);
  assign ahb_resp_out  = (state_q == ERR1) || (state_q == ERR2);
  assign unused_addr   = ^ms_riscv32_mp_dmaddr_in[1:0];
`else
  assign ahb_ready_out = (state_q != WAIT);
  assign ahb_resp_out  = 1'b0;
  assign unused_addr   = ^{ms_riscv32_mp_dmaddr_in[31:AW+2], ms_riscv32_mp_dmaddr_in[1:0]};
`endif

  assign ms_riscv32_mp_dmdata_rd_out = rd_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    widx_d   = widx_q;
    data_d   = data_q;
    mask_d   = mask_q;
    wr_d     = wr_q;
    rd_d     = rd_q;
    acc_en   = 1'b0;
    acc_wr   = wr_q;
    acc_idx  = widx_q;
    acc_data = data_q;
    acc_mask = mask_q;
    accept   = ahb_ready_out && ahb_htrans_in[1];

    if (accept) begin
`ifdef MSRV32_DMEM_RANGE_CHECK_EN
      if (oor) begin
        state_d = ERR1;
      end else
`endif
      if (WAIT_STATES == 0) begin
        // Zero wait states: the access happens on the accept edge straight from the bus.
        state_d  = IDLE;
        acc_en   = 1'b1;
        acc_wr   = ms_riscv32_mp_dmwr_req_in;
        acc_idx  = in_idx;
        acc_data = ms_riscv32_mp_dmdata_in;
        acc_mask = ms_riscv32_mp_dmwr_mask_in;
      end else begin
        state_d = WAIT;
        cnt_d   = 4'(WAIT_STATES);
        widx_d  = in_idx;
        data_d  = ms_riscv32_mp_dmdata_in;
        mask_d  = ms_riscv32_mp_dmwr_mask_in;
        wr_d    = ms_riscv32_mp_dmwr_req_in;
      end
    end else begin
      case (state_q)
        WAIT: begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            acc_en  = 1'b1;
            state_d = IDLE;
          end
        end
`ifdef MSRV32_DMEM_RANGE_CHECK_EN
        ERR1:    state_d = ERR2;
        ERR2:    state_d = IDLE;
`endif
        default: state_d = IDLE;
      endcase
    end

    if (acc_en && !acc_wr) begin
      rd_d = mem[acc_idx];
    end

    // Reset wins over everything, including a completing or newly accepted write.
    if (ms_riscv32_mp_rst_in) begin
      state_d = IDLE;
      cnt_d   = 4'd0;
      rd_d    = 32'd0;
      widx_d  = '0;
      data_d  = 32'd0;
      mask_d  = 4'd0;
      wr_d    = 1'b0;
      acc_en  = 1'b0;
    end
  end

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    state_q <= state_d;
    cnt_q   <= cnt_d;
    widx_q  <= widx_d;
    data_q  <= data_d;
    mask_q  <= mask_d;
    wr_q    <= wr_d;
    rd_q    <= rd_d;
  end

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    for (int b = 0; b < 4; b++) begin
      if (acc_en && acc_wr && acc_mask[b]) begin
        mem[acc_idx][8*b +: 8] <= acc_data[8*b +: 8];
      end
    end
  end
endmodule

// File: tb/tb_msrv32_dmem_responder.sv
// tb/tb_msrv32_dmem_responder.sv - directed bench for msrv32_dmem_responder at 0, 1 and 3 wait states
module tb_msrv32_dmem_responder;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr, wdata;
  logic [3:0]  mask;
  logic        wr;
  logic [1:0]  ht0, ht1, ht3;
  logic [31:0] rd0, rd1, rd3;
  logic        rdy0, rdy1, rdy3;
  logic        rsp0, rsp1, rsp3;
  int          cmp = 0;
  int          mis = 0;

  always #5 clk = ~clk;

  msrv32_dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) dut0 (
    .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_in(rst),
    .ms_riscv32_mp_dmaddr_in(addr), .ms_riscv32_mp_dmdata_in(wdata),
    .ms_riscv32_mp_dmwr_mask_in(mask), .ms_riscv32_mp_dmwr_req_in(wr),
    .ahb_htrans_in(ht0), .ms_riscv32_mp_dmdata_rd_out(rd0),
    .ahb_ready_out(rdy0), .ahb_resp_out(rsp0));

  msrv32_dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(1)) dut1 (
    .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_in(rst),
    .ms_riscv32_mp_dmaddr_in(addr), .ms_riscv32_mp_dmdata_in(wdata),
    .ms_riscv32_mp_dmwr_mask_in(mask), .ms_riscv32_mp_dmwr_req_in(wr),
    .ahb_htrans_in(ht1), .ms_riscv32_mp_dmdata_rd_out(rd1),
    .ahb_ready_out(rdy1), .ahb_resp_out(rsp1));

  msrv32_dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(3)) dut3 (
    .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_in(rst),
    .ms_riscv32_mp_dmaddr_in(addr), .ms_riscv32_mp_dmdata_in(wdata),
    .ms_riscv32_mp_dmwr_mask_in(mask), .ms_riscv32_mp_dmwr_req_in(wr),
    .ahb_htrans_in(ht3), .ms_riscv32_mp_dmdata_rd_out(rd3),
    .ahb_ready_out(rdy3), .ahb_resp_out(rsp3));

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Offers one NONSEQ transfer to the instance with 'ws' wait states and returns just after the accept edge.
  task automatic start(input int ws, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] m, input logic w);
    addr = a; wdata = d; mask = m; wr = w;
    case (ws)
      0:       ht0 = 2'b10;
      1:       ht1 = 2'b10;
      default: ht3 = 2'b10;
    endcase
    cyc(1);
    ht0 = 2'b00; ht1 = 2'b00; ht3 = 2'b00;
  endtask

  task automatic run(input int ws, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] m, input logic w);
    start(ws, a, d, m, w);
    cyc(ws);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    cmp++; if (rdy0 !== 1'b1) begin mis++; $display("FAIL reset_rdy0 got %b want 1", rdy0); end
    cmp++; if (rdy1 !== 1'b1) begin mis++; $display("FAIL reset_rdy1 got %b want 1", rdy1); end
    cmp++; if (rsp1 !== 1'b0) begin mis++; $display("FAIL reset_rsp1 got %b want 0", rsp1); end
    cmp++; if (rd1 !== 32'h0) begin mis++; $display("FAIL reset_rd1 got %h want 00000000", rd1); end
    cmp++; if (rdy3 !== 1'b1) begin mis++; $display("FAIL reset_rdy3 got %b want 1", rdy3); end
    cmp++; if (rd3 !== 32'h0) begin mis++; $display("FAIL reset_rd3 got %h want 00000000", rd3); end
  endtask

  task automatic test_byte_write;
    run(1, 32'h0, 32'h11223344, 4'b1111, 1'b1);
    start(1, 32'h1, 32'h0000FF00, 4'b0010, 1'b1);
    cmp++; if (rdy1 !== 1'b0) begin mis++; $display("FAIL byte_wait_rdy got %b want 0", rdy1); end
    cyc(1);
    cmp++; if (rdy1 !== 1'b1) begin mis++; $display("FAIL byte_done_rdy got %b want 1", rdy1); end
    cmp++; if (rsp1 !== 1'b0) begin mis++; $display("FAIL byte_done_rsp got %b want 0", rsp1); end
    run(1, 32'h0, 32'h0, 4'b0000, 1'b0);
    cmp++; if (rd1 !== 32'h1122FF44) begin mis++; $display("FAIL byte_rd got %h want 1122ff44", rd1); end
  endtask

  task automatic test_halfword_word;
    run(1, 32'h2, 32'hFFFF0000, 4'b1100, 1'b1);
    run(1, 32'h0, 32'h0, 4'b0000, 1'b0);
    cmp++; if (rd1 !== 32'hFFFFFF44) begin mis++; $display("FAIL half_rd got %h want ffffff44", rd1); end
    run(1, 32'h8, 32'hAAAAAAAA, 4'b1111, 1'b1);
    run(1, 32'h8, 32'h0, 4'b0000, 1'b0);
    cmp++; if (rd1 !== 32'hAAAAAAAA) begin mis++; $display("FAIL word_rd got %h want aaaaaaaa", rd1); end
    run(1, 32'hC, 32'h55555555, 4'b1111, 1'b1);
    cmp++; if (rd1 !== 32'hAAAAAAAA) begin mis++; $display("FAIL write_keeps_rd got %h want aaaaaaaa", rd1); end
    run(1, 32'h8, 32'h0, 4'b0000, 1'b1);
    cmp++; if (rsp1 !== 1'b0) begin mis++; $display("FAIL mask0_rsp got %b want 0", rsp1); end
    run(1, 32'h8, 32'h0, 4'b0000, 1'b0);
    cmp++; if (rd1 !== 32'hAAAAAAAA) begin mis++; $display("FAIL mask0_rd got %h want aaaaaaaa", rd1); end
  endtask

  task automatic test_back_to_back;
    addr = 32'h4; wdata = 32'h12345678; mask = 4'b1111; wr = 1'b1; ht0 = 2'b10;
    cyc(1);
    cmp++; if (rdy0 !== 1'b1) begin mis++; $display("FAIL b2b_wr_rdy got %b want 1", rdy0); end
    wr = 1'b0; wdata = 32'h0; ht0 = 2'b11;
    cyc(1);
    ht0 = 2'b00;
    cmp++; if (rdy0 !== 1'b1) begin mis++; $display("FAIL b2b_rd_rdy got %b want 1", rdy0); end
    cmp++; if (rd0 !== 32'h12345678) begin mis++; $display("FAIL b2b_rd got %h want 12345678", rd0); end
  endtask

  task automatic test_hold_wait;
    int low;
    run(3, 32'h14, 32'h01010101, 4'b1111, 1'b1);
    addr = 32'h10; wdata = 32'hCAFEF00D; mask = 4'b1111; wr = 1'b1; ht3 = 2'b10;
    cyc(1);
    addr = 32'h14; wdata = 32'hDEADBEEF;
    low = 0;
    while (rdy3 === 1'b0 && low < 10) begin
      low++;
      cyc(1);
    end
    ht3 = 2'b00;
    cmp++; if (low !== 3) begin mis++; $display("FAIL wait_low_cycles got %0d want 3", low); end
    run(3, 32'h10, 32'h0, 4'b0000, 1'b0);
    cmp++; if (rd3 !== 32'hCAFEF00D) begin mis++; $display("FAIL wait_rd_target got %h want cafef00d", rd3); end
    run(3, 32'h14, 32'h0, 4'b0000, 1'b0);
    cmp++; if (rd3 !== 32'h01010101) begin mis++; $display("FAIL wait_ignored_addr got %h want 01010101", rd3); end
  endtask

  task automatic test_range;
    run(1, 32'h0, 32'h01020304, 4'b1111, 1'b1);
    start(1, 32'h1000, 32'h99999999, 4'b1111, 1'b1);
`ifdef MSRV32_DMEM_RANGE_CHECK_EN
    cmp++; if (rdy1 !== 1'b0 || rsp1 !== 1'b1) begin mis++; $display("FAIL err1 got rdy=%b rsp=%b want rdy=0 rsp=1", rdy1, rsp1); end
    cyc(1);
    cmp++; if (rdy1 !== 1'b1 || rsp1 !== 1'b1) begin mis++; $display("FAIL err2 got rdy=%b rsp=%b want rdy=1 rsp=1", rdy1, rsp1); end
    cyc(1);
    cmp++; if (rsp1 !== 1'b0) begin mis++; $display("FAIL err_exit_rsp got %b want 0", rsp1); end
    run(1, 32'h0, 32'h0, 4'b0000, 1'b0);
    cmp++; if (rd1 !== 32'h01020304) begin mis++; $display("FAIL range_mem got %h want 01020304", rd1); end
`else
    cmp++; if (rdy1 !== 1'b0 || rsp1 !== 1'b0) begin mis++; $display("FAIL wrap_wait got rdy=%b rsp=%b want rdy=0 rsp=0", rdy1, rsp1); end
    cyc(1);
    cmp++; if (rdy1 !== 1'b1) begin mis++; $display("FAIL wrap_done_rdy got %b want 1", rdy1); end
    run(1, 32'h0, 32'h0, 4'b0000, 1'b0);
    cmp++; if (rd1 !== 32'h99999999) begin mis++; $display("FAIL wrap_mem got %h want 99999999", rd1); end
`endif
  endtask

  task automatic test_reset_in_wait;
    run(3, 32'h18, 32'h66666666, 4'b1111, 1'b1);
    run(3, 32'h18, 32'h0, 4'b0000, 1'b0);
    cmp++; if (rd3 !== 32'h66666666) begin mis++; $display("FAIL rstw_pre_rd got %h want 66666666", rd3); end
    start(3, 32'h18, 32'h77777777, 4'b1111, 1'b1);
    cyc(1);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    cmp++; if (rdy3 !== 1'b1) begin mis++; $display("FAIL rstw_rdy got %b want 1", rdy3); end
    cmp++; if (rd3 !== 32'h0) begin mis++; $display("FAIL rstw_rd got %h want 00000000", rd3); end
    cyc(3);
    run(3, 32'h18, 32'h0, 4'b0000, 1'b0);
    cmp++; if (rd3 !== 32'h66666666) begin mis++; $display("FAIL rstw_mem got %h want 66666666", rd3); end
  endtask

  initial begin
    rst = 1'b1; addr = 32'h0; wdata = 32'h0; mask = 4'b0000; wr = 1'b0;
    ht0 = 2'b00; ht1 = 2'b00; ht3 = 2'b00;
    #1;
    test_reset;
    test_byte_write;
    test_halfword_word;
    test_back_to_back;
    test_hold_wait;
    test_range;
    test_reset_in_wait;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
    $finish;
  end
endmodule
